// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and constants for the byte-stream memory loader.
//   state_t      - loader FSM states
//   HDR_FIELD_W  - width of the address and length header fields (two bytes each)
// Provides fallback values for the global `REG_WIDTH / `MEM_DEPTH defines when
// the surrounding build has not already set them.

`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

`ifndef MEM_DEPTH
`define MEM_DEPTH 65536
`endif

package mem_loader_pkg;

    // Address and length are both sent as two little-endian bytes.
    localparam int HDR_FIELD_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream input and RAM write port of the memory loader.
//   in_valid/in_data/in_ready - valid/ready byte stream from the host link
//   mem_we/mem_addr/mem_wdata - single-byte RAM write port
// Modports:
//   master - the loader (consumes the stream, drives the RAM port)
//   slave  - the host/RAM side

interface mem_loader_if #(
    parameter int DATA_W = `REG_WIDTH,
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: parses framed packets from a valid/ready byte stream and issues
// single-byte RAM writes, holding the CPU in reset while a load is running.
//
// Packet: addr_lo, addr_hi, len_lo, len_hi, payload[len], [checksum]
//
// Ports:
//   i_clk       - system clock, rising edge
//   i_reset_n   - synchronous active-low reset
//   i_load_en   - permits start of a packet (only looked at in IDLE)
//   bus         - mem_loader_if.master: byte stream in, RAM write port out
//   o_cpu_hold  - high from first header byte until DONE/ERR exit
//   o_done      - one-cycle pulse after a successful packet
//   o_error     - sticky fault flag, cleared by reset or next header byte
//
// Build option: define MEM_LOADER_CHECKSUM_EN to add a trailing checksum byte;
// the 8-bit sum of header, payload and checksum must be zero.

module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int DATA_W    = `REG_WIDTH,
    parameter int ADDR_W    = HDR_FIELD_W,
    parameter int MEM_DEPTH = `MEM_DEPTH
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load_en,
    mem_loader_if.master bus,
    output logic         o_cpu_hold,
    output logic         o_done,
    output logic         o_error
);

    // One past the last writable address; 17 bits so a full 64K depth fits.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = CSUM;
`else
    localparam state_t PAYLOAD_END = DONE;
`endif

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_addr;
    logic [HDR_FIELD_W-1:0] r_remain;
    logic [DATA_W-1:0]      r_len_lo;
    logic                   r_we;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic                   r_cpu_hold;
    logic                   r_done;
    logic                   r_error;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_in_range;
    logic [HDR_FIELD_W-1:0] w_len;

    // in_ready is decoded from state so header and payload bytes stream at
    // one per cycle with no bubble. Forced low while reset is asserted.
    always_comb begin
        w_ready = 1'b0;
        if (i_reset_n) begin
            case (r_state)
                IDLE:                          w_ready = i_load_en;
                ADDR_HI, LEN_LO, LEN_HI, DATA: w_ready = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
                CSUM:                          w_ready = 1'b1;
`endif
                default:                       w_ready = 1'b0;
            endcase
        end
    end

    assign w_accept   = bus.in_valid & w_ready;
    assign w_in_range = ({1'b0, r_addr} < DEPTH_LIM);
    assign w_len      = {bus.in_data, r_len_lo};

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
    logic [DATA_W-1:0] w_csum_next;

    assign w_csum_next = r_csum + bus.in_data;

    // Running sum of every accepted byte; restarts on the first header byte.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= (r_state == IDLE) ? bus.in_data : w_csum_next;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_len_lo   <= '0;
            r_we       <= 1'b0;
            r_mem_addr <= '0;
            r_wdata    <= '0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr     <= {{(ADDR_W-DATA_W){1'b0}}, bus.in_data};
                        r_cpu_hold <= 1'b1;
                        r_error    <= 1'b0;
                        r_state    <= ADDR_HI;
                    end
                end
                ADDR_HI: begin
                    if (w_accept) begin
                        r_addr[ADDR_W-1:DATA_W] <= bus.in_data;
                        r_state                 <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= bus.in_data;
                        r_state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_accept) begin
                        r_remain <= w_len;
                        r_state  <= (w_len == '0) ? PAYLOAD_END : DATA;
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        if (w_in_range) begin
                            r_we       <= 1'b1;
                            r_mem_addr <= r_addr;
                            r_wdata    <= bus.in_data;
                            r_addr     <= r_addr + 1'b1;  // wraps mod 2^ADDR_W
                            r_remain   <= r_remain - 1'b1;
                            if (r_remain == HDR_FIELD_W'(1))
                                r_state <= PAYLOAD_END;
                        end else begin
                            // Offending byte is swallowed; the rest of the
                            // payload is left for the host to discard.
                            r_error <= 1'b1;
                            r_state <= ERR;
                        end
                    end
                end
`ifdef MEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (w_accept) begin
                        if (w_csum_next == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ERR;
                        end
                    end
                end
`endif
                // Reached the cycle after the final write, so done and the
                // cpu_hold release always trail the last mem_we.
                DONE: begin
                    r_done     <= 1'b1;
                    r_cpu_hold <= 1'b0;
                    r_state    <= IDLE;
                end
                ERR: begin
                    r_cpu_hold <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_wdata;
    assign o_cpu_hold    = r_cpu_hold;
    assign o_done        = r_done;
    assign o_error       = r_error;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed + randomized bench for mem_loader. Two instances:
// a full 64K-deep one for the main traffic and a 1K-deep one for the
// out-of-range case; sel picks which one the stream goes to and is observed.

module tb_mem_loader;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       load_en;
    logic       tb_valid;
    logic [7:0] tb_data;
    logic       sel;

    always #5 clk = ~clk;

    mem_loader_if #(.DATA_W(8), .ADDR_W(16)) bif ();
    mem_loader_if #(.DATA_W(8), .ADDR_W(16)) sif ();

    logic big_hold, big_done, big_err, sm_hold, sm_done, sm_err;

    assign bif.in_valid = tb_valid & ~sel;
    assign bif.in_data  = tb_data;
    assign sif.in_valid = tb_valid & sel;
    assign sif.in_data  = tb_data;

    mem_loader #(.DATA_W(8), .ADDR_W(16), .MEM_DEPTH(65536)) u_big (
        .i_clk(clk), .i_reset_n(reset_n), .i_load_en(load_en), .bus(bif),
        .o_cpu_hold(big_hold), .o_done(big_done), .o_error(big_err)
    );

    mem_loader #(.DATA_W(8), .ADDR_W(16), .MEM_DEPTH(1024)) u_small (
        .i_clk(clk), .i_reset_n(reset_n), .i_load_en(load_en), .bus(sif),
        .o_cpu_hold(sm_hold), .o_done(sm_done), .o_error(sm_err)
    );

    logic        o_ready, o_we, o_hold, o_done, o_error;
    logic [15:0] o_addr;
    logic [7:0]  o_wdata;
    assign o_ready = sel ? sif.in_ready  : bif.in_ready;
    assign o_we    = sel ? sif.mem_we    : bif.mem_we;
    assign o_addr  = sel ? sif.mem_addr  : bif.mem_addr;
    assign o_wdata = sel ? sif.mem_wdata : bif.mem_wdata;
    assign o_hold  = sel ? sm_hold : big_hold;
    assign o_done  = sel ? sm_done : big_done;
    assign o_error = sel ? sm_err  : big_err;

    typedef logic [23:0] wr_t;  // {addr, data}

    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, done_cnt, last_we_cyc, done_cyc, hold_fall_cyc;
    logic prev_hold = 1'b0;
    wr_t  got_q[$], exp_q[$], saved_q[$];
    logic [7:0] pkt[$], pay[$];
    bit   exp_done, exp_err;
    int   n_consume;

    // Output monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (o_we) begin
            got_q.push_back({o_addr, o_wdata});
            last_we_cyc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_hold && !o_hold) hold_fall_cyc = cyc;
        prev_hold = o_hold;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame the packet and predict writes/done/error from
    // the packet rules (wrap mod 64K, stop at first address >= depth).
    task automatic build(input logic [15:0] addr, input int depth, input bit bad_csum);
        int   s;
        int   a;
        bit   csum_on;
        logic [7:0] c;
        logic [15:0] len;
        csum_on = 1'b0;
        len = 16'(pay.size());
        pkt = {};
        exp_q = {};
        exp_err = 1'b0;
        exp_done = 1'b0;
        pkt.push_back(addr[7:0]);
        pkt.push_back(addr[15:8]);
        pkt.push_back(len[7:0]);
        pkt.push_back(len[15:8]);
        foreach (pay[i]) pkt.push_back(pay[i]);
        s = 0;
        foreach (pkt[i]) s += int'(pkt[i]);
        c = 8'((256 - (s % 256)) % 256);
        if (bad_csum) c = c + 8'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
        csum_on = 1'b1;
        pkt.push_back(c);
`endif
        n_consume = pkt.size();
        for (int i = 0; i < pay.size(); i++) begin
            a = (int'(addr) + i) % 65536;
            if (a >= depth) begin
                exp_err = 1'b1;
                n_consume = 4 + i + 1;
                break;
            end
            exp_q.push_back({a[15:0], pay[i]});
        end
        if (!exp_err) begin
            if (csum_on && bad_csum) exp_err = 1'b1;
            else exp_done = 1'b1;
        end
    endtask

    // Drive pkt[0..n-1]; starts and ends on a falling edge.
    task automatic send(input int n, input bit gaps, input bit drop_le);
        for (int i = 0; i < n; i++) begin
            int t;
            bit ok;
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    tb_valid = 1'b0;
                    @(negedge clk);
                end
            end
            tb_valid = 1'b1;
            tb_data  = pkt[i];
            t  = 0;
            ok = 1'b0;
            while (!ok && t < 50) begin
                #2;
                ok = o_ready;
                @(negedge clk);
                t++;
            end
            if (!ok) begin
                check("ready_timeout", {31'd0, ok}, 32'd1);
                tb_valid = 1'b0;
                return;
            end
            if (drop_le && i == 0) load_en = 1'b0;
        end
        tb_valid = 1'b0;
    endtask

    task automatic clear_mon();
        got_q = {};
        done_cnt = 0;
        last_we_cyc = -1;
        done_cyc = -1;
        hold_fall_cyc = -1;
    endtask

    task automatic run(input string name, input bit gaps, input bit drop_le);
        @(negedge clk);
        clear_mon();
        send(n_consume, gaps, drop_le);
        repeat (8) @(negedge clk);
        load_en = 1'b1;
        check({name, ".n_writes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s.write%0d", name, i), got_q[i], exp_q[i]);
        check({name, ".done_cnt"}, done_cnt, {31'd0, exp_done});
        check({name, ".error"}, {31'd0, o_error}, {31'd0, exp_err});
        check({name, ".cpu_hold"}, {31'd0, o_hold}, 32'd0);
        if (exp_done && exp_q.size() > 0) begin
            check({name, ".done_after_we"}, {31'd0, done_cyc > last_we_cyc}, 32'd1);
            check({name, ".hold_after_we"}, {31'd0, hold_fall_cyc > last_we_cyc}, 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        sel = 1'b0; reset_n = 1'b0; load_en = 1'b0; tb_valid = 1'b0; tb_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst.in_ready",  {31'd0, o_ready}, 32'd0);
        check("rst.mem_we",    {31'd0, o_we},    32'd0);
        check("rst.mem_addr",  {16'd0, o_addr},  32'd0);
        check("rst.mem_wdata", {24'd0, o_wdata}, 32'd0);
        check("rst.cpu_hold",  {31'd0, o_hold},  32'd0);
        check("rst.done",      {31'd0, o_done},  32'd0);
        check("rst.error",     {31'd0, o_error}, 32'd0);

        // load_en low: a waiting byte must not start a packet.
        reset_n = 1'b1;
        tb_valid = 1'b1; tb_data = 8'h55;
        repeat (3) @(negedge clk);
        check("noload.in_ready", {31'd0, o_ready}, 32'd0);
        check("noload.cpu_hold", {31'd0, o_hold},  32'd0);
        tb_valid = 1'b0;
        load_en = 1'b1;
        #2;
        check("idle.in_ready", {31'd0, o_ready}, 32'd1);

        pay = {8'h11, 8'h22, 8'h33, 8'h44};
        build(16'h0200, 65536, 1'b0);
        run("basic", 1'b0, 1'b0);

        pay = {};
        build(16'h0000, 65536, 1'b0);
        run("len0", 1'b0, 1'b0);

        // Wrap, with load_en dropped after the first header byte.
        pay = {8'hA5, 8'h5A};
        build(16'hFFFF, 65536, 1'b0);
        run("wrap", 1'b0, 1'b1);

        // Bad checksum (no effect when the checksum is compiled out).
        pay = {8'h07, 8'h08};
        build(16'h0040, 65536, 1'b1);
        run("badcsum", 1'b0, 1'b0);

        // Out-of-range on the 1K instance, then a good packet clears error.
        @(negedge clk);
        sel = 1'b1;
        pay = {8'hDE, 8'hAD};
        build(16'd1023, 1024, 1'b0);
        run("oob", 1'b0, 1'b0);
        pay = {8'h01, 8'h02, 8'h03};
        build(16'h0010, 1024, 1'b0);
        run("after_oob", 1'b0, 1'b0);
        @(negedge clk);
        sel = 1'b0;

        // Random packets, gapless then with random valid gaps.
        for (int k = 0; k < 4; k++) begin
            ra = 16'($urandom);
            pay = {};
            repeat ($urandom_range(1, 8)) pay.push_back(8'($urandom));
            build(ra, 65536, 1'b0);
            run($sformatf("rnd%0d", k), 1'b0, 1'b0);
            saved_q = got_q;
            run($sformatf("rnd%0d_gap", k), 1'b1, 1'b0);
            check($sformatf("rnd%0d.gap_same", k), {31'd0, got_q == saved_q}, 32'd1);
        end

        // Reset in the middle of the payload.
        pay = {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        build(16'h0300, 65536, 1'b0);
        @(negedge clk);
        clear_mon();
        send(6, 1'b0, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        check("midrst.in_ready",  {31'd0, o_ready}, 32'd0);
        check("midrst.mem_we",    {31'd0, o_we},    32'd0);
        check("midrst.mem_addr",  {16'd0, o_addr},  32'd0);
        check("midrst.mem_wdata", {24'd0, o_wdata}, 32'd0);
        check("midrst.cpu_hold",  {31'd0, o_hold},  32'd0);
        check("midrst.done",      {31'd0, o_done},  32'd0);
        check("midrst.error",     {31'd0, o_error}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pay = {8'h9A, 8'hBC, 8'hDE};
        build(16'h0400, 65536, 1'b0);
        run("post_rst", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
